// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, baud table and divisor helper for uart_frame_tx (UART_TX_PARITY_EN adds the PARITY state)
package uart_pkg;

  // Frame sequencer states; PARITY exists only in parity-enabled builds.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  // Supported line rates indexed by baud_sel; any other selector falls back to entry 0.
  localparam int unsigned BAUD_TABLE [5] = '{9600, 19200, 38400, 57600, 115200};

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO feeding the UART transmitter
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - FIFO-fed UART frame transmitter with repeat mode; define UART_TX_PARITY_EN for a parity bit
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    baud_sel,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  input  logic                          repeat_en,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(calc_div(CLK_HZ, BAUD_TABLE[0]) + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_0 = DIV_W'(calc_div(CLK_HZ, BAUD_TABLE[0]));
  localparam logic [DIV_W-1:0] DIV_1 = DIV_W'(calc_div(CLK_HZ, BAUD_TABLE[1]));
  localparam logic [DIV_W-1:0] DIV_2 = DIV_W'(calc_div(CLK_HZ, BAUD_TABLE[2]));
  localparam logic [DIV_W-1:0] DIV_3 = DIV_W'(calc_div(CLK_HZ, BAUD_TABLE[3]));
  localparam logic [DIV_W-1:0] DIV_4 = DIV_W'(calc_div(CLK_HZ, BAUD_TABLE[4]));

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               rep_valid_q, rep_valid_d;
  logic [DIV_W-1:0]   sel_div;
  logic               bit_end, launch, tx_int, tx_done_int;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_int;

`ifdef UART_TX_PARITY_EN
  logic odd_q, odd_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign s_ready    = !rst && !fifo_full;
  assign fifo_push  = s_valid && s_ready;
  assign bit_end    = (cnt_q == div_q - 1'b1);
  assign tx         = rst | tx_int;
  assign busy       = !rst && (state_q != ST_IDLE);
  assign tx_done    = !rst && tx_done_int;
  assign fifo_level = rst ? '0 : fifo_level_int;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_int)
  );

  // Rate lookup; reserved selector codes fall back to the slowest rate.
  always_comb begin
    case (baud_sel)
      3'd1:    sel_div = DIV_1;
      3'd2:    sel_div = DIV_2;
      3'd3:    sel_div = DIV_3;
      3'd4:    sel_div = DIV_4;
      default: sel_div = DIV_0;
    endcase
  end

  // Frame sequencer: fresh FIFO data wins over repeating the previous word.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    word_d      = word_q;
    rep_valid_d = rep_valid_q;
    fifo_pop    = 1'b0;
    launch      = 1'b0;
    tx_int      = 1'b1;
    tx_done_int = 1'b0;
`ifdef UART_TX_PARITY_EN
    odd_d       = odd_q;
`endif
    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          word_d      = fifo_rdata;
          rep_valid_d = 1'b1;
          launch      = 1'b1;
        end else if (repeat_en && rep_valid_q) begin
          launch = 1'b1;
        end
        if (launch) begin
          state_d   = ST_START;
          div_d     = sel_div;
          cnt_d     = '0;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          odd_d     = parity_odd;
`endif
        end
      end
      ST_START: begin
        tx_int = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_int = word_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_int = (^word_q) ^ odd_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_int = 1'b1;
        if (bit_end) begin
          if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
            tx_done_int = 1'b1;
            bit_idx_d   = '0;
            state_d     = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any frame and forgets the repeat word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      word_q      <= '0;
      rep_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      word_q      <= word_d;
      rep_valid_q <= rep_valid_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity sense captured at frame launch so mid-frame changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (rst) odd_q <= 1'b0;
    else     odd_q <= odd_d;
  end
`endif

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - scoreboard bench for uart_frame_tx (honours UART_TX_PARITY_EN)
module tb_uart_frame_tx;

  localparam int CLK_HZ     = 1_000_000;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [2:0]                    baud_sel;
  logic                          s_valid;
  logic [DATA_W-1:0]             s_data;
  logic                          s_ready;
  logic                          repeat_en;
  logic                          parity_odd;
  logic                          tx;
  logic                          busy;
  logic                          tx_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLK_HZ(CLK_HZ), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .repeat_en(repeat_en), .parity_odd(parity_odd), .tx(tx),
    .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
  );

  logic [DATA_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit saw_full = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int model_div(input int sel);
    int baud;
    case (sel)
      1: baud = 19200;
      2: baud = 38400;
      3: baud = 57600;
      4: baud = 115200;
      default: baud = 9600;
    endcase
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  // Monitor state: snapshots of the previous cycle decide what the next launch must carry.
  bit                m_in_frame = 0, m_prev_idle = 0, m_prev_rep = 0, m_prev_odd = 0;
  bit                m_last_valid = 0, m_active = 0, m_expect;
  int                m_prev_qsize = 0, m_prev_baud = 4;
  int                m_div = 1, m_cyc = 0, m_bit, m_mism, m_busy_bad, m_done_bad, m_ones;
  int                m_bits[16];
  logic [DATA_W-1:0] m_word, m_last_word = '0, m_got;

  initial begin
    forever begin
      @(negedge clk);
      m_active = 0;
      if (rst) begin
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        m_in_frame   = 0;
        m_last_valid = 0;
      end else begin
        if (!m_in_frame) begin
          m_expect = m_prev_idle && (m_prev_qsize > 0 || (m_prev_rep && m_last_valid));
          chk("launch", (tx === 1'b0) ? 1 : 0, m_expect ? 1 : 0);
          if (m_expect && tx === 1'b0) begin
            if (m_prev_qsize > 0) m_word = exp_q.pop_front();
            else                  m_word = m_last_word;
            m_last_word  = m_word;
            m_last_valid = 1;
            m_div        = model_div(m_prev_baud);
            m_bits[0]    = 0;
            m_ones       = 0;
            for (int i = 0; i < DATA_W; i++) begin
              m_bits[1+i] = (m_word >> i) & 1;
              m_ones += m_bits[1+i];
            end
            if (PAR_BITS == 1) m_bits[1+DATA_W] = (m_ones % 2) ^ int'(m_prev_odd);
            for (int s = 0; s < STOP_BITS; s++) m_bits[1+DATA_W+PAR_BITS+s] = 1;
            m_cyc = 0; m_mism = 0; m_busy_bad = 0; m_done_bad = 0; m_got = '0;
            m_in_frame = 1;
          end else begin
            chk("idle_lines", {tx, busy, tx_done}, 3'b100);
          end
        end
        if (m_in_frame) begin
          m_active = 1;
          m_bit = m_cyc / m_div;
          if (int'(tx) != m_bits[m_bit]) m_mism++;
          if (busy !== 1'b1) m_busy_bad++;
          if (tx_done !== (m_cyc == FRAME_BITS * m_div - 1)) m_done_bad++;
          if (m_bit >= 1 && m_bit <= DATA_W && (m_cyc % m_div) == m_div / 2) m_got[m_bit-1] = tx;
          if (m_cyc == FRAME_BITS * m_div - 1) begin
            chk("frame_word", m_got, m_word);
            chk("frame_bit_timing", m_mism, 0);
            chk("frame_busy", m_busy_bad, 0);
            chk("frame_tx_done", m_done_bad, 0);
            m_in_frame = 0;
          end else begin
            m_cyc++;
          end
        end
        chk("fifo_level", fifo_level, exp_q.size());
        chk("s_ready", s_ready, (exp_q.size() < FIFO_DEPTH) ? 1 : 0);
      end
      m_prev_idle  = !rst && !m_active;
      m_prev_qsize = exp_q.size();
      m_prev_rep   = repeat_en;
      m_prev_odd   = parity_odd;
      m_prev_baud  = baud_sel;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    bit ok = 0;
    int tries = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!ok && tries < 20000) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok && !rst) begin
        chk("full_level", fifo_level, FIFO_DEPTH);
        saw_full = 1;
      end
      @(posedge clk);
      if (ok) exp_q.push_back(d);
      #1;
      tries++;
    end
    s_valid = 1'b0;
    chk("push_accept", int'(ok), 1);
  endtask

  task automatic drain(input int limit);
    int quiet = 0;
    for (int c = 0; c < limit && quiet < 3; c++) begin
      @(negedge clk);
      quiet = (!busy && exp_q.size() == 0) ? quiet + 1 : 0;
    end
    chk("drain", (quiet >= 3) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int limit);
    bit seen = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("wait_busy", int'(seen), 1);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; baud_sel = 3'd4; repeat_en = 1'b0; parity_odd = 1'b0;
    idle(4);
    rst = 1'b0;

    // Single alternating frame at the fastest rate.
    push_word(8'h55);
    drain(3000);

    // Parity sense both ways on the same word.
    parity_odd = 1'b0; push_word(8'h07); drain(3000);
    parity_odd = 1'b1; push_word(8'h07); drain(3000);
    parity_odd = 1'b0;

    // Overfill: 20 back-to-back words, producer must stall at 16 queued.
    saw_full = 0;
    for (int i = 0; i < 20; i++) push_word(DATA_W'(i));
    chk("saw_full", int'(saw_full), 1);
    drain(5000);

    // Repeat mode, then fresh data overriding the repeated word.
    repeat_en = 1'b1;
    push_word(8'hA3);
    idle(250);
    push_word(8'h3C);
    idle(250);
    repeat_en = 1'b0;
    drain(3000);

    // Rate change mid-frame only affects the following frame; reserved code 6 runs at 9600.
    baud_sel = 3'd4;
    push_word(8'h5A);
    push_word(8'hC3);
    idle(30);
    baud_sel = 3'd0;
    drain(5000);
    baud_sel = 3'd6;
    push_word(8'h96);
    idle(20);
    baud_sel = 3'd4;
    drain(5000);

    // Reset in the middle of data bit 3 with words still queued.
    push_word(8'hF0);
    push_word(8'h11);
    push_word(8'h22);
    wait_busy(100);
    idle((1 + 3) * model_div(4) + model_div(4) / 2);
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    repeat_en = 1'b1;
    idle(300);
    repeat_en = 1'b0;
    drain(3000);

    // Randomised traffic with random rate, parity sense and occasional repeat.
    for (int n = 0; n < 60; n++) begin
      baud_sel   = 3'($urandom_range(2, 4));
      parity_odd = 1'($urandom_range(0, 1));
      repeat_en  = ($urandom_range(0, 7) == 0);
      push_word(DATA_W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 200));
    end
    repeat_en = 1'b0;
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
